// File: rtl/pipelined_rca_adder_if.sv
// Streaming operand/result bundle for pipelined_rca_adder.
// master: operand source plus result consumer. slave: the adder itself.
interface pipelined_rca_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output in_valid, in1, in2, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );

    modport slave (
        input  in_valid, in1, in2, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
endinterface

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit in1 + in2 + c_in.
// The carry chain is cut into STAGES chunks of CW = WIDTH/STAGES bits.
// Each chunk is added in its own register stage.
// A stage carries forward:
//   - the sum bits already finished,
//   - the operand bits not yet added,
//   - the chunk carry.
// The last stage drives sum/c_out/out_valid directly from registers.
// A stall (out_valid & ~out_ready) freezes every stage at once.
// Optional macro OVF_DETECT_EN adds a registered signed-overflow flag.
// Without it the overflow port is tied to 0.
module pipelined_rca_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic                  clk,
    input logic                  rst,
    pipelined_rca_adder_if.slave bus
);
    localparam int CW = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_rca_adder: WIDTH must be divisible by STAGES and 1 <= STAGES <= WIDTH");
    end

    // Bit-serial ripple add of one chunk; returns {carry_out, sum}
    function automatic logic [CW:0] chunk_add(
        input logic [CW-1:0] a,
        input logic [CW-1:0] b,
        input logic          ci
    );
        logic [CW-1:0] s;
        logic          c;
        s = {CW{1'b0}};
        c = ci;
        for (int i = 0; i < CW; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    logic stall_s;

    assign stall_s      = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE_W = (k + 1) * CW;   // sum bits finished after this stage
        localparam int SRC_W  = WIDTH - k * CW; // operand bits still to add at this stage

        logic [SRC_W-1:0]  a_src_s;
        logic [SRC_W-1:0]  b_src_s;
        logic              cin_s;
        logic              vin_s;
        logic [DONE_W-1:0] sum_nxt_s;
        logic [CW:0]       add_s;
        logic              load_s;
        logic              valid_r;
        logic              carry_r;
        logic [DONE_W-1:0] sum_r;

        if (k == 0) begin : g_src
            assign a_src_s   = bus.in1;
            assign b_src_s   = bus.in2;
            assign cin_s     = bus.c_in;
            assign vin_s     = bus.in_valid;
            assign sum_nxt_s = add_s[CW-1:0];
        end else begin : g_src
            assign a_src_s   = g_stage[k-1].g_fwd.a_rem_r;
            assign b_src_s   = g_stage[k-1].g_fwd.b_rem_r;
            assign cin_s     = g_stage[k-1].carry_r;
            assign vin_s     = g_stage[k-1].valid_r;
            assign sum_nxt_s = {add_s[CW-1:0], g_stage[k-1].sum_r};
        end

        assign add_s  = chunk_add(a_src_s[CW-1:0], b_src_s[CW-1:0], cin_s);
        assign load_s = ~stall_s & vin_s;

        // Valid bit advances with the pipe (bubbles included) and holds during a stall
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_r <= 1'b0;
            end else if (!stall_s) begin
                valid_r <= vin_s;
            end
        end

        // Data loads only when a valid item moves in, so bubbles never disturb held data
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                carry_r <= 1'b0;
                sum_r   <= {DONE_W{1'b0}};
            end else if (load_s) begin
                carry_r <= add_s[CW];
                sum_r   <= sum_nxt_s;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [SRC_W-CW-1:0] a_rem_r;
            logic [SRC_W-CW-1:0] b_rem_r;

            // Carry the not-yet-added upper operand bits to the next stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_rem_r <= {(SRC_W-CW){1'b0}};
                    b_rem_r <= {(SRC_W-CW){1'b0}};
                end else if (load_s) begin
                    a_rem_r <= a_src_s[SRC_W-1:CW];
                    b_rem_r <= b_src_s[SRC_W-1:CW];
                end
            end
        end

`ifdef OVF_DETECT_EN
        if (k == STAGES - 1) begin : g_ovf
            logic msb_cin_s;
            logic ovf_r;

            // Carry into the MSB recovered from the MSB sum bit and its operand bits
            assign msb_cin_s = add_s[CW-1] ^ a_src_s[CW-1] ^ b_src_s[CW-1];

            // Overflow flag registered alongside the last chunk, same hold rules as c_out
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (load_s) begin
                    ovf_r <= msb_cin_s ^ add_s[CW];
                end
            end
        end
`endif
    end

    assign bus.out_valid = g_stage[STAGES-1].valid_r;
    assign bus.sum       = g_stage[STAGES-1].sum_r;
    assign bus.c_out     = g_stage[STAGES-1].carry_r;
`ifdef OVF_DETECT_EN
    assign bus.overflow  = g_stage[STAGES-1].g_ovf.ovf_r;
`else
    assign bus.overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed bench for pipelined_rca_adder.
// Three instances: STAGES=4 (main), STAGES=1 and STAGES=16.
module tb_pipelined_rca_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

`ifdef OVF_DETECT_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    pipelined_rca_adder_if #(.WIDTH(16)) bus4  ();
    pipelined_rca_adder_if #(.WIDTH(16)) bus1  ();
    pipelined_rca_adder_if #(.WIDTH(16)) bus16 ();

    pipelined_rca_adder #(.WIDTH(16), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    pipelined_rca_adder #(.WIDTH(16), .STAGES(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    pipelined_rca_adder #(.WIDTH(16), .STAGES(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int errors = 0;
    int checks = 0;

    // Directed stream: {in1, in2, c_in} -> {sum, c_out, ovf}
    localparam logic [15:0] T_A   [6] = '{16'h6A6A, 16'h6A6A, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
    localparam logic [15:0] T_B   [6] = '{16'h2E66, 16'h2E66, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};
    localparam logic        T_CI  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [15:0] T_S   [6] = '{16'h98D0, 16'h98D1, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    localparam logic        T_CO  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic        T_OV  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Backpressure stream
    localparam logic [15:0] BP_A  [8] = '{16'h0001, 16'h1000, 16'h00FF, 16'h8000, 16'h1234, 16'hF0F0, 16'hABCD, 16'hFFFF};
    localparam logic [15:0] BP_B  [8] = '{16'h0001, 16'h2000, 16'h0001, 16'h8000, 16'h4321, 16'h0F0F, 16'h0000, 16'h0002};
    localparam logic [15:0] BP_S  [8] = '{16'h0002, 16'h3000, 16'h0100, 16'h0000, 16'h5555, 16'hFFFF, 16'hABCD, 16'h0001};
    localparam logic        BP_CO [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic        BP_OV [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          tx;
    int          rx;
    logic        prev_stall;
    logic [15:0] held_sum;
    logic        held_cout;

    initial begin
        rst = 1'b1;
        bus4.in_valid  = 1'b0; bus4.in1  = 16'h0000; bus4.in2  = 16'h0000; bus4.c_in  = 1'b0; bus4.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0; bus1.in1  = 16'h0000; bus1.in2  = 16'h0000; bus1.c_in  = 1'b0; bus1.out_ready  = 1'b1;
        bus16.in_valid = 1'b0; bus16.in1 = 16'h0000; bus16.in2 = 16'h0000; bus16.c_in = 1'b0; bus16.out_ready = 1'b1;

        // Reset state
        #1;
        check("rst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        check("rst_sum",       {16'd0, bus4.sum},       32'd0);
        check("rst_c_out",     {31'd0, bus4.c_out},     32'd0);
        check("rst_overflow",  {31'd0, bus4.overflow},  32'd0);
        check("rst_in_ready",  {31'd0, bus4.in_ready},  32'd1);
        tick();
        tick();
        rst = 1'b0;

        // Back-to-back directed vectors, latency 4, then idle hold
        for (int c = 0; c < 11; c++) begin
            if (c < 6) begin
                bus4.in_valid = 1'b1;
                bus4.in1 = T_A[c]; bus4.in2 = T_B[c]; bus4.c_in = T_CI[c];
            end else begin
                bus4.in_valid = 1'b0;
            end
            tick();
            if (c == 2) begin
                check("lat_not_yet_valid", {31'd0, bus4.out_valid}, 32'd0);
            end else if ((c >= 3) && (c <= 8)) begin
                check("vec_out_valid", {31'd0, bus4.out_valid}, 32'd1);
                check("vec_sum",       {16'd0, bus4.sum},       {16'd0, T_S[c-3]});
                check("vec_c_out",     {31'd0, bus4.c_out},     {31'd0, T_CO[c-3]});
                check("vec_overflow",  {31'd0, bus4.overflow},  {31'd0, T_OV[c-3] & OVF_ON});
            end else if (c >= 9) begin
                check("idle_out_valid", {31'd0, bus4.out_valid}, 32'd0);
                check("idle_sum_hold",  {16'd0, bus4.sum},       32'h7FFF);
                check("idle_cout_hold", {31'd0, bus4.c_out},     32'd1);
            end
        end

        // Backpressure: 8 vectors streamed, consumer stalls 5 cycles mid-stream
        tx = 0;
        rx = 0;
        prev_stall = 1'b0;
        held_sum = 16'h0000;
        held_cout = 1'b0;
        for (int cyc = 0; (cyc < 40) && (rx < 8); cyc++) begin
            bus4.out_ready = !((cyc >= 5) && (cyc < 10));
            bus4.in_valid  = (tx < 8);
            bus4.c_in      = 1'b0;
            if (tx < 8) begin
                bus4.in1 = BP_A[tx];
                bus4.in2 = BP_B[tx];
            end
            #1;
            if (prev_stall) begin
                check("stall_sum_stable",  {16'd0, bus4.sum},   {16'd0, held_sum});
                check("stall_cout_stable", {31'd0, bus4.c_out}, {31'd0, held_cout});
            end
            if (bus4.out_valid && !bus4.out_ready) begin
                check("stall_in_ready", {31'd0, bus4.in_ready}, 32'd0);
                held_sum   = bus4.sum;
                held_cout  = bus4.c_out;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus4.out_valid && bus4.out_ready) begin
                check("bp_sum",      {16'd0, bus4.sum},      {16'd0, BP_S[rx]});
                check("bp_c_out",    {31'd0, bus4.c_out},    {31'd0, BP_CO[rx]});
                check("bp_overflow", {31'd0, bus4.overflow}, {31'd0, BP_OV[rx] & OVF_ON});
                rx++;
            end
            if (bus4.in_valid && bus4.in_ready) begin
                tx++;
            end
            @(posedge clk);
            #1;
        end
        check("bp_all_received", rx, 32'd8);
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        tick();

        // Reset mid-operation: 3 accepted operands discarded
        for (int i = 0; i < 3; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in1 = 16'h1111; bus4.in2 = 16'h1111; bus4.c_in = 1'b0;
            tick();
        end
        bus4.in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, bus4.out_valid}, 32'd0);
        check("midrst_sum",       {16'd0, bus4.sum},       32'd0);
        check("midrst_c_out",     {31'd0, bus4.c_out},     32'd0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("postrst_no_valid", {31'd0, bus4.out_valid}, 32'd0);
        end

        // STAGES=1 and STAGES=16: full-chain carry and latency
        bus1.in_valid = 1'b1;  bus1.in1 = 16'hFFFF;  bus1.in2 = 16'hFFFF;  bus1.c_in = 1'b1;
        bus16.in_valid = 1'b1; bus16.in1 = 16'hFFFF; bus16.in2 = 16'hFFFF; bus16.c_in = 1'b1;
        tick();
        check("s1_out_valid", {31'd0, bus1.out_valid}, 32'd1);
        check("s1_sum0",      {16'd0, bus1.sum},       32'hFFFF);
        check("s1_cout0",     {31'd0, bus1.c_out},     32'd1);
        bus1.in1 = 16'h1234;  bus1.in2 = 16'h4321;
        bus16.in1 = 16'h1234; bus16.in2 = 16'h4321;
        tick();
        bus1.in_valid = 1'b0;
        bus16.in_valid = 1'b0;
        check("s1_sum1",  {16'd0, bus1.sum},   32'h5556);
        check("s1_cout1", {31'd0, bus1.c_out}, 32'd0);
        check("s1_ovf1",  {31'd0, bus1.overflow}, 32'd0);
        for (int e = 3; e <= 17; e++) begin
            tick();
            if (e == 3) begin
                check("s1_drained", {31'd0, bus1.out_valid}, 32'd0);
            end
            if (e == 15) begin
                check("s16_not_yet_valid", {31'd0, bus16.out_valid}, 32'd0);
            end
            if (e == 16) begin
                check("s16_out_valid", {31'd0, bus16.out_valid}, 32'd1);
                check("s16_sum0",      {16'd0, bus16.sum},       32'hFFFF);
                check("s16_cout0",     {31'd0, bus16.c_out},     32'd1);
            end
            if (e == 17) begin
                check("s16_sum1",  {16'd0, bus16.sum},      32'h5556);
                check("s16_cout1", {31'd0, bus16.c_out},    32'd0);
                check("s16_ovf1",  {31'd0, bus16.overflow}, 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
